ex_muldiv_seq: RTL and testbench

//  Iterative unsigned multiply/divide sequencer beside the EX-stage ALU; executes MUL/MULHU/DIVU/REMU over multiple cycles.

---
 rtl/ex_pkg.sv | 21 ++
 rtl/ex_muldiv_seq_if.sv | 27 ++
 rtl/muldiv_dp.sv | 86 ++++++++
 rtl/ex_muldiv_seq.sv | 113 +++++++++++
 tb/tb_ex_muldiv_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: mul/div op encodings and sequencer FSM states.
package ex_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// Pipeline-facing bundle of the iterative mul/div sequencer.
interface ex_muldiv_seq_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 4
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [RD_W-1:0] rd_in;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;

    modport master (
        output start, op, A, B, rd_in, flush,
        input  stall, busy, done, result, rd_out
    );

    modport slave (
        input  start, op, A, B, rd_in, flush,
        output stall, busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_dp.sv
// Shared shift-add / restoring shift-subtract datapath with result mux.
// MULDIV_EARLY_OUT_EN: report when the multiplier runs out of set bits.
module muldiv_dp
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            early,
    output logic [XLEN-1:0] res_next
);

    // acc: product (mul) or partial remainder in the low half (div)
    // sh:  shifted multiplicand (mul) or dividend/quotient in the low half (div)
    // opb: multiplier (mul) or divisor (div)
    logic [2*XLEN-1:0] acc_q, acc_d, sh_q, sh_d;
    logic [XLEN-1:0]   opb_q, opb_d, rem_sub;
    logic [XLEN:0]     rem_t;
    logic              ge;

    always_comb begin
        acc_d   = acc_q;
        sh_d    = sh_q;
        opb_d   = opb_q;
        rem_t   = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
        ge      = rem_t >= {1'b0, opb_q};
        // Only used when ge, where the difference always fits in XLEN bits
        rem_sub = rem_t[XLEN-1:0] - opb_q;
        if (load) begin
            opb_d = b;
            if (is_div(op) && b == '0) begin
                acc_d = {{XLEN{1'b0}}, a};
                sh_d  = {{XLEN{1'b0}}, {XLEN{1'b1}}};
            end else begin
                acc_d = '0;
                sh_d  = {{XLEN{1'b0}}, a};
            end
        end else if (step) begin
            if (is_div(op)) begin
                sh_d  = {{XLEN{1'b0}}, sh_q[XLEN-2:0], ge};
                acc_d = {{XLEN{1'b0}}, ge ? rem_sub : rem_t[XLEN-1:0]};
            end else begin
                if (opb_q[0]) acc_d = acc_q + sh_q;
                sh_d  = sh_q << 1;
                opb_d = opb_q >> 1;
            end
        end
    end

    always_comb begin
        res_next = '0;
        unique case (op)
            OP_MUL:   res_next = acc_d[XLEN-1:0];
            OP_MULHU: res_next = acc_d[2*XLEN-1:XLEN];
            OP_DIVU:  res_next = sh_d[XLEN-1:0];
            OP_REMU:  res_next = acc_d[XLEN-1:0];
            default:  res_next = '0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    // The current step consumes the last set multiplier bit
    assign early = (opb_q[XLEN-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            sh_q  <= '0;
            opb_q <= '0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            opb_q <= opb_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage iterative unsigned MUL/MULHU/DIVU/REMU sequencer: FSM, counter, stall/done.
// MULDIV_EARLY_OUT_EN (in muldiv_dp) lets multiplies finish once the multiplier is exhausted.
module ex_muldiv_seq
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 4
) (
    input logic             clk,
    input logic             rst,
    ex_muldiv_seq_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e             op_q, op_sel, op_in;
    logic [RD_W-1:0] rd_q, rd_out_q;
    logic [XLEN-1:0] result_q, res_next;
    logic            done_q, done_d;
    logic            load, step, early, last, stall;

    assign op_in = op_e'(bus.op);
    assign last  = (cnt_q == CNT_W'(XLEN - 1)) | (~is_div(op_q) & early);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        done_d  = 1'b0;
        stall   = 1'b0;
        op_sel  = op_q;
        unique case (state_q)
            ST_IDLE: begin
                op_sel = op_in;
                // flush wins over a same-cycle start
                if (bus.start && !bus.flush) begin
                    stall = 1'b1;
                    load  = 1'b1;
                    cnt_d = '0;
                    if (is_div(op_in) && bus.B == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    muldiv_dp #(
        .XLEN(XLEN)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .op      (op_sel),
        .a       (bus.A),
        .b       (bus.B),
        .early   (early),
        .res_next(res_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (load) begin
                op_q <= op_in;
                rd_q <= bus.rd_in;
            end
            if (done_d) begin
                result_q <= res_next;
                rd_out_q <= (state_q == ST_IDLE) ? bus.rd_in : rd_q;
            end
        end
    end

    assign bus.stall  = stall;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: arithmetic/latency model checked every cycle plus directed literals.
module tb_ex_muldiv_seq;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_seq_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    ex_muldiv_seq #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Number of RUN iterations an accepted op spends before done
    function automatic int iters(input logic [1:0] op, input logic [31:0] b);
        int n;
        n = 32;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            n = 1;
            for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Model: 0 idle, 1 computing, 2 reporting
    int          m_st     = 0;
    int          m_left   = 0;
    logic [31:0] m_pend   = '0;
    logic [3:0]  m_pend_rd = '0;
    logic        e_done   = 1'b0;
    logic [31:0] e_result = '0;
    logic [3:0]  e_rd     = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = 0; m_left = 0; e_done = 1'b0; e_result = '0; e_rd = '0;
        end else begin
            e_done = 1'b0;
            case (m_st)
                0: if (bus.start && !bus.flush) begin
                    m_pend    = golden(bus.op, bus.A, bus.B);
                    m_pend_rd = bus.rd_in;
                    if (bus.op[1] && bus.B == 0) begin
                        m_st = 2; e_done = 1'b1; e_result = m_pend; e_rd = m_pend_rd;
                    end else begin
                        m_st = 1; m_left = iters(bus.op, bus.B);
                    end
                end
                1: if (bus.flush) m_st = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) begin
                           m_st = 2; e_done = 1'b1; e_result = m_pend; e_rd = m_pend_rd;
                       end
                   end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("done", bus.done, e_done);
            check("busy", bus.busy, m_st != 0);
            check("stall", bus.stall, (bus.start && m_st == 0 && !bus.flush) || m_st == 1);
            check("result", bus.result, e_result);
            check("rd_out", bus.rd_out, e_rd);
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] rd, input logic [31:0] exp,
                          input int lat, input bit hold);
        int cycles;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b; bus.rd_in = rd;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        cycles = 1;
        while (!bus.done && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!bus.done) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_lat"}, cycles, lat);
            check({name, "_val"}, bus.result, exp);
            check({name, "_rd"}, bus.rd_out, rd);
        end
        if (hold) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    int lat_76, lat_b0, lat_b2;

    initial begin
`ifdef MULDIV_EARLY_OUT_EN
        lat_76 = 4; lat_b0 = 2; lat_b2 = 3;
`else
        lat_76 = 33; lat_b0 = 33; lat_b2 = 33;
`endif
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.rd_in = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 4'd3, 32'd42, lat_76, 1'b0);
        run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'h0000_0001, 33, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 4'd1, 32'd14, 33, 1'b1);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 4'd2, 32'd2, 33, 1'b0);
        run_op("divu_ff_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 4'd10, 32'd1, 33, 1'b0);
        run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 4'd11, 32'h7FFF_FFFF, 33, 1'b0);
        run_op("mul_b0", 2'b00, 32'd123, 32'd0, 4'd12, 32'd0, lat_b0, 1'b0);
        run_op("mul_b2", 2'b00, 32'h8000_0001, 32'd2, 4'd13, 32'h0000_0002, lat_b2, 1'b0);
        run_op("mulhu_b2", 2'b01, 32'h8000_0001, 32'd2, 4'd14, 32'h0000_0001, lat_b2, 1'b0);
        run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 4'd4, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 4'd8, 32'd5, 1, 1'b0);

        // Flush a multiply in its tenth cycle
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd3; bus.B = 32'hFFFF_FFFF; bus.rd_in = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_result", bus.result, 32'd5);
        repeat (3) begin @(posedge clk); #1; check("flush_nodone", bus.done, 0); end
        run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 4'd15, 32'd3, 33, 1'b0);

        // start and flush together in idle
        @(posedge clk); #1;
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b10; bus.B = 32'd0;
        #3 check("sf_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("sf_busy", bus.busy, 0);
        check("sf_done", bus.done, 0);

        // Asynchronous reset mid-run
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd7; bus.B = 32'hFFFF_FFFF; bus.rd_in = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_result", bus.result, 0);
        check("arst_rd", bus.rd_out, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_op("post_rst", 2'b10, 32'd100, 32'd7, 4'd2, 32'd14, 33, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
